cpu_clk_ctrl: RTL and testbench



---
 rtl/cpu_clk_ctrl_if.sv | 25 ++
 rtl/cpu_clk_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle for cpu_clk_ctrl: run/step/divide requests in,
// CPU clock-enable, phase and state reporting out.
interface cpu_clk_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             run;
    logic             step;
    logic             div_ld;
    logic [DIV_W-1:0] div_val;
    logic             cpu_ce;
    logic             cpu_ph;
    logic             busy;
    logic [1:0]       state;
    logic [31:0]      cyc_cnt;

    modport master (
        output run, step, div_ld, div_val,
        input  cpu_ce, cpu_ph, busy, state, cyc_cnt
    );

    modport slave (
        input  run, step, div_ld, div_val,
        output cpu_ce, cpu_ph, busy, state, cyc_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step CPU clock-enable sequencer with programmable period.
// Optional CYCLE_CNT_EN macro adds a 32-bit issued-enable counter on cyc_cnt.
module cpu_clk_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_clk_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DEFAULT_DIV_V = DIV_W'(DEFAULT_DIV);

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [DIV_W-1:0] div_shadow_reg, div_shadow_next;
    logic             ce_reg, ce_next;
    logic             ph_reg, ph_next;
    logic             boundary;

    // Last cycle of an active period; the enable for it appears one clk later.
    assign boundary = (state_reg != HALT) && (cnt_reg == div_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= HALT;
            cnt_reg        <= '0;
            div_reg        <= DEFAULT_DIV_V;
            div_shadow_reg <= DEFAULT_DIV_V;
            ce_reg         <= 1'b0;
            ph_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            div_reg        <= div_next;
            div_shadow_reg <= div_shadow_next;
            ce_reg         <= ce_next;
            ph_reg         <= ph_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        div_next        = div_reg;
        div_shadow_next = div_shadow_reg;
        ce_next         = boundary;
        ph_next         = ph_reg ^ ce_reg;

        if (bus.div_ld) begin
            div_shadow_next = bus.div_val;
        end

        case (state_reg)
            HALT: begin
                cnt_next = '0;
                if (bus.div_ld) begin
                    div_next = bus.div_val;
                end
                if (bus.run) begin
                    state_next = RUN;
                end else if (bus.step) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_next = '0;
                    // A load on the boundary itself bypasses the shadow.
                    div_next = bus.div_ld ? bus.div_val : div_shadow_reg;
                    if (!bus.run) begin
                        state_next = HALT;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STEP: begin
                if (boundary) begin
                    cnt_next   = '0;
                    div_next   = bus.div_ld ? bus.div_val : div_shadow_reg;
                    state_next = HALT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = HALT;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.cpu_ce = ce_reg;
    assign bus.cpu_ph = ph_reg;
    assign bus.busy   = (state_reg != HALT);
    assign bus.state  = state_reg;

`ifdef CYCLE_CNT_EN
    logic [31:0] cyc_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_reg <= '0;
        end else if (ce_reg) begin
            cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
        end
    end

    assign bus.cyc_cnt = cyc_cnt_reg;
`else
    assign bus.cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: expected enable cycles are queued when
// stimulus is applied and matched against cpu_ce/cpu_ph/cyc_cnt every cycle.
module tb_cpu_clk_ctrl;
    logic clk = 1'b0;
    logic reset_n;

    cpu_clk_ctrl_if #(.DIV_W(8)) bus ();

    cpu_clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_q[$];
    logic        ph_exp = 1'b0;
    logic [31:0] cyc_exp = 32'd0;
    logic [31:0] cyc_base;
    int          n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [31:0] cnt_model();
`ifdef CYCLE_CNT_EN
        return cyc_exp;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance k cycles, popping the scoreboard whenever an enable is due.
    task automatic run_cycles(input int k);
        logic exp_ce;
        for (int i = 0; i < k; i++) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0] < cyc) void'(exp_q.pop_front());
            exp_ce = (exp_q.size() > 0 && exp_q[0] == cyc);
            if (exp_ce) void'(exp_q.pop_front());
            chk("cpu_ce", bus.cpu_ce, exp_ce);
            chk("cpu_ph", bus.cpu_ph, ph_exp);
            chk("cyc_cnt", bus.cyc_cnt, cnt_model());
            $display("cycle %0d ce=%0b ph=%0b state=%0d busy=%0b cyc_cnt=%0d",
                     cyc, bus.cpu_ce, bus.cpu_ph, bus.state, bus.busy, bus.cyc_cnt);
            if (exp_ce) begin
                ph_exp  = ~ph_exp;
                cyc_exp = cyc_exp + 32'd1;
            end
        end
    endtask

    task automatic load_div_halt(input logic [7:0] v);
        bus.div_ld  = 1'b1;
        bus.div_val = v;
        run_cycles(1);
        bus.div_ld  = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.div_ld  = 1'b0;
        bus.div_val = 8'd0;
        #3;
        chk("rst_ce", bus.cpu_ce, 0);
        chk("rst_state", bus.state, 0);
        chk("rst_busy", bus.busy, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // div=0 continuous run: enable every clk, phase toggling each clk
        load_div_halt(8'd0);
        bus.run = 1'b1;
        n = cyc;
        for (int k = 0; k < 8; k++) exp_q.push_back(n + 2 + k);
        run_cycles(1);
        chk("run_state", bus.state, 1);
        chk("run_busy", bus.busy, 1);
        run_cycles(7);
        bus.run = 1'b0;
        run_cycles(1);
        chk("div0_halt", bus.state, 0);
        run_cycles(3);

        // div=3 single step; a second step mid-period is ignored
        load_div_halt(8'd3);
        bus.step = 1'b1;
        n = cyc;
        exp_q.push_back(n + 5);
        run_cycles(1);
        chk("step_state", bus.state, 2);
        chk("step_busy1", bus.busy, 1);
        bus.step = 1'b0;
        run_cycles(1);
        bus.step = 1'b1;
        run_cycles(1);
        bus.step = 1'b0;
        chk("step_busy3", bus.busy, 1);
        run_cycles(1);
        chk("step_busy4", bus.busy, 1);
        run_cycles(2);
        chk("step_done", bus.state, 0);
        chk("step_idle", bus.busy, 0);
        run_cycles(5);

        // div=4 run, drop run two cycles after an enable: one more period then halt
        load_div_halt(8'd4);
        bus.run = 1'b1;
        n = cyc;
        exp_q.push_back(n + 6);
        exp_q.push_back(n + 11);
        run_cycles(11);
        n = cyc;
        run_cycles(2);
        bus.run = 1'b0;
        exp_q.push_back(n + 5);
        run_cycles(4);
        chk("drop_halt", bus.state, 0);
        run_cycles(8);

        // div=2 run, mid-period load of 5, then boundary-cycle loads
        load_div_halt(8'd2);
        bus.run = 1'b1;
        n = cyc;
        exp_q.push_back(n + 4);
        run_cycles(4);
        n = cyc;
        run_cycles(1);
        bus.div_ld = 1'b1; bus.div_val = 8'd5;
        run_cycles(1);
        bus.div_ld = 1'b0;
        exp_q.push_back(n + 3);
        exp_q.push_back(n + 9);
        exp_q.push_back(n + 15);
        run_cycles(13);
        n = cyc;
        exp_q.push_back(n + 6);
        exp_q.push_back(n + 9);
        exp_q.push_back(n + 15);
        run_cycles(5);
        bus.div_ld = 1'b1; bus.div_val = 8'd2;
        run_cycles(1);
        bus.div_ld = 1'b0;
        run_cycles(2);
        bus.div_ld = 1'b1; bus.div_val = 8'd5;
        run_cycles(1);
        bus.div_ld = 1'b0;
        run_cycles(1);
        bus.run = 1'b0;
        run_cycles(5);
        run_cycles(4);
        chk("div_ld_halt", bus.state, 0);

        // async reset in the middle of a div=3 run
        load_div_halt(8'd3);
        bus.run = 1'b1;
        n = cyc;
        exp_q.push_back(n + 5);
        run_cycles(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ce", bus.cpu_ce, 0);
        chk("arst_ph", bus.cpu_ph, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_state", bus.state, 0);
        chk("arst_cyc_cnt", bus.cyc_cnt, 0);
        bus.run = 1'b0;
        exp_q.delete();
        ph_exp  = 1'b0;
        cyc_exp = 32'd0;
        tick();
        reset_n = 1'b1;

        // divide register back at its reset default of 1: period of two clks
        bus.run = 1'b1;
        n = cyc;
        exp_q.push_back(n + 3);
        exp_q.push_back(n + 5);
        run_cycles(4);
        bus.run = 1'b0;
        run_cycles(4);
        chk("rst_div_halt", bus.state, 0);

        // ten single steps at div=0
        load_div_halt(8'd0);
        cyc_base = cyc_exp;
        for (int s = 0; s < 10; s++) begin
            bus.step = 1'b1;
            n = cyc;
            exp_q.push_back(n + 2);
            run_cycles(1);
            bus.step = 1'b0;
            run_cycles(1);
        end
        run_cycles(1);
`ifdef CYCLE_CNT_EN
        chk("cyc_cnt_10", bus.cyc_cnt, cyc_base + 32'd10);

        // counter wraps from all-ones to zero
        force dut.cyc_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt_reg;
        cyc_exp = 32'hFFFF_FFFF;
        bus.step = 1'b1;
        n = cyc;
        exp_q.push_back(n + 2);
        run_cycles(1);
        bus.step = 1'b0;
        run_cycles(2);
        chk("cyc_cnt_wrap", bus.cyc_cnt, 32'd0);
`else
        chk("cyc_cnt_off", bus.cyc_cnt, 32'd0);
`endif
        run_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
